// File: rtl/trv_exec_monitor.sv
// Execution monitor for TRV32I: detects ECALL / illegal / stall timeout, drains, latches status.
// Optional simulation X-checking of retire inputs is enabled by defining TRV_MON_XCHECK_EN.
module trv_exec_monitor #(
    parameter int unsigned XLEN         = 32,
    parameter logic [31:0] HALT_INST    = 32'h0000_0073,
    parameter int unsigned DRAIN_CYCLES = 4,
    parameter int unsigned TIMEOUT      = 1024,
    parameter int unsigned TRACE_DEPTH  = 8,
    parameter int unsigned CNT_W        = 32,
    localparam int unsigned IDX_W       = $clog2(TRACE_DEPTH)
) (
    input  logic             clk,
    input  logic             rst,
    input  logic             ret_valid,
    input  logic [XLEN-1:0]  ret_pc,
    input  logic [31:0]      ret_inst,
    output logic             halted,
    output logic [1:0]       halt_cause,
    output logic [XLEN-1:0]  halt_pc,
    output logic [CNT_W-1:0] cycle_cnt,
    output logic [CNT_W-1:0] retire_cnt,
    input  logic [IDX_W-1:0] trace_idx,
    output logic [XLEN-1:0]  trace_pc
);

    localparam int unsigned STALL_W = (TIMEOUT > 0) ? $clog2(TIMEOUT + 1) : 1;
    localparam int unsigned DRAIN_W = (DRAIN_CYCLES > 1) ? $clog2(DRAIN_CYCLES) : 1;
    localparam int unsigned FILL_W  = IDX_W + 1;

    localparam logic [STALL_W-1:0] STALL_LAST = STALL_W'((TIMEOUT > 0) ? TIMEOUT - 1 : 0);
    localparam logic [DRAIN_W-1:0] DRAIN_INIT = DRAIN_W'(DRAIN_CYCLES - 1);
    localparam logic [FILL_W-1:0]  FILL_MAX   = FILL_W'(TRACE_DEPTH);

    localparam logic [1:0] CAUSE_HALT    = 2'd1;
    localparam logic [1:0] CAUSE_ILLEGAL = 2'd2;
    localparam logic [1:0] CAUSE_TIMEOUT = 2'd3;

    typedef enum logic [1:0] {StRun, StDrain, StHalt} state_e;

    state_e             state_q, state_d;
    logic [CNT_W-1:0]   cycle_q, cycle_d;
    logic [CNT_W-1:0]   retire_q, retire_d;
    logic [STALL_W-1:0] stall_q, stall_d;
    logic [DRAIN_W-1:0] drain_q, drain_d;
    logic [IDX_W-1:0]   wptr_q, wptr_d;
    logic [FILL_W-1:0]  fill_q, fill_d;
    logic [1:0]         cause_q, cause_d;
    logic [XLEN-1:0]    cpc_q, cpc_d;
    logic               halted_q, halted_d;
    logic [1:0]         hcause_q, hcause_d;
    logic [XLEN-1:0]    hpc_q, hpc_d;

    logic [XLEN-1:0]    trace_mem [TRACE_DEPTH];
    logic               trace_we;
    logic [XLEN-1:0]    last_pc;
    logic [IDX_W-1:0]   rd_ptr;

    logic               det;
    logic [1:0]         det_cause;
    logic [XLEN-1:0]    det_pc;
    logic               x_valid;
    logic               x_data;

    function automatic logic [CNT_W-1:0] sat_inc(input logic [CNT_W-1:0] v);
        return (&v) ? v : v + CNT_W'(1);
    endfunction

    function automatic logic is_illegal(input logic [31:0] w);
        return (w[1:0] != 2'b11) || (w == 32'h0000_0000) || (&w);
    endfunction

`ifdef TRV_MON_XCHECK_EN
    assign x_valid = $isunknown(ret_valid);
    assign x_data  = $isunknown(ret_inst) || $isunknown(ret_pc);

    always_ff @(posedge clk) begin
        if (state_q == StRun && det) begin
            $display("%0t trv_exec_monitor: halt detected, cause %0d pc %h", $time, det_cause,
                     det_pc);
        end
    end
`else
    assign x_valid = 1'b0;
    assign x_data  = 1'b0;
`endif

    // Unwritten entries are reset to 0, so this also yields 0 for a timeout with no retire.
    assign last_pc = trace_mem[wptr_q - IDX_W'(1)];
    assign rd_ptr  = wptr_q - IDX_W'(1) - trace_idx;

    always_comb begin
        state_d   = state_q;
        cycle_d   = cycle_q;
        retire_d  = retire_q;
        stall_d   = stall_q;
        drain_d   = drain_q;
        wptr_d    = wptr_q;
        fill_d    = fill_q;
        cause_d   = cause_q;
        cpc_d     = cpc_q;
        halted_d  = halted_q;
        hcause_d  = hcause_q;
        hpc_d     = hpc_q;
        trace_we  = 1'b0;
        det       = 1'b0;
        det_cause = 2'd0;
        det_pc    = '0;

        unique case (state_q)
            StRun: begin
                cycle_d = sat_inc(cycle_q);
                if (x_valid) begin
                    det       = 1'b1;
                    det_cause = CAUSE_ILLEGAL;
                    det_pc    = '0;
                end else if (ret_valid) begin
                    retire_d = sat_inc(retire_q);
                    trace_we = 1'b1;
                    wptr_d   = wptr_q + IDX_W'(1);
                    stall_d  = '0;
                    if (fill_q != FILL_MAX) begin
                        fill_d = fill_q + FILL_W'(1);
                    end
                    if (x_data) begin
                        det       = 1'b1;
                        det_cause = CAUSE_ILLEGAL;
                        det_pc    = ret_pc;
                    end else if (ret_inst == HALT_INST) begin
                        det       = 1'b1;
                        det_cause = CAUSE_HALT;
                        det_pc    = ret_pc;
                    end else if (is_illegal(ret_inst)) begin
                        det       = 1'b1;
                        det_cause = CAUSE_ILLEGAL;
                        det_pc    = ret_pc;
                    end
                end else begin
                    if (stall_q != '1) begin
                        stall_d = stall_q + STALL_W'(1);
                    end
                    if (TIMEOUT != 0 && stall_q == STALL_LAST) begin
                        det       = 1'b1;
                        det_cause = CAUSE_TIMEOUT;
                        det_pc    = last_pc;
                    end
                end
                if (det) begin
                    state_d = StDrain;
                    drain_d = DRAIN_INIT;
                    cause_d = det_cause;
                    cpc_d   = det_pc;
                end
            end
            StDrain: begin
                if (drain_q == '0) begin
                    state_d = StHalt;
                end else begin
                    drain_d = drain_q - DRAIN_W'(1);
                end
            end
            StHalt: begin
                halted_d = 1'b1;
                hcause_d = cause_q;
                hpc_d    = cpc_q;
            end
            default: state_d = StRun;
        endcase
    end

    always_ff @(posedge clk or negedge rst) begin
        if (!rst) begin
            state_q  <= StRun;
            cycle_q  <= '0;
            retire_q <= '0;
            stall_q  <= '0;
            drain_q  <= '0;
            wptr_q   <= '0;
            fill_q   <= '0;
            cause_q  <= '0;
            cpc_q    <= '0;
            halted_q <= 1'b0;
            hcause_q <= '0;
            hpc_q    <= '0;
        end else begin
            state_q  <= state_d;
            cycle_q  <= cycle_d;
            retire_q <= retire_d;
            stall_q  <= stall_d;
            drain_q  <= drain_d;
            wptr_q   <= wptr_d;
            fill_q   <= fill_d;
            cause_q  <= cause_d;
            cpc_q    <= cpc_d;
            halted_q <= halted_d;
            hcause_q <= hcause_d;
            hpc_q    <= hpc_d;
        end
    end

    always_ff @(posedge clk or negedge rst) begin
        if (!rst) begin
            for (int i = 0; i < TRACE_DEPTH; i++) begin
                trace_mem[i] <= '0;
            end
        end else if (trace_we) begin
            trace_mem[wptr_q] <= ret_pc;
        end
    end

    assign halted     = halted_q;
    assign halt_cause = hcause_q;
    assign halt_pc    = hpc_q;
    assign cycle_cnt  = cycle_q;
    assign retire_cnt = retire_q;
    assign trace_pc   = ({1'b0, trace_idx} < fill_q) ? trace_mem[rd_ptr] : '0;

endmodule

// File: tb/tb_trv_exec_monitor.sv
// Randomized + directed bench for trv_exec_monitor against a scenario-level reference model.
module tb_trv_exec_monitor;

    localparam int unsigned XLEN  = 32;
    localparam int unsigned DRAIN = 4;
    localparam int unsigned TMO   = 16;
    localparam int unsigned DEPTH = 8;
    localparam int unsigned CW    = 32;
    localparam int unsigned IW    = 3;
    localparam logic [31:0] ECALL = 32'h0000_0073;
    localparam logic [31:0] NOP   = 32'h0000_0013;

    logic            clk = 1'b0;
    logic            rst = 1'b0;
    logic            ret_valid = 1'b0;
    logic [XLEN-1:0] ret_pc = '0;
    logic [31:0]     ret_inst = '0;
    logic            halted;
    logic [1:0]      halt_cause;
    logic [XLEN-1:0] halt_pc;
    logic [CW-1:0]   cycle_cnt;
    logic [CW-1:0]   retire_cnt;
    logic [IW-1:0]   trace_idx = '0;
    logic [XLEN-1:0] trace_pc;

    trv_exec_monitor #(
        .XLEN        (XLEN),
        .HALT_INST   (ECALL),
        .DRAIN_CYCLES(DRAIN),
        .TIMEOUT     (TMO),
        .TRACE_DEPTH (DEPTH),
        .CNT_W       (CW)
    ) dut (
        .clk       (clk),
        .rst       (rst),
        .ret_valid (ret_valid),
        .ret_pc    (ret_pc),
        .ret_inst  (ret_inst),
        .halted    (halted),
        .halt_cause(halt_cause),
        .halt_pc   (halt_pc),
        .cycle_cnt (cycle_cnt),
        .retire_cnt(retire_cnt),
        .trace_idx (trace_idx),
        .trace_pc  (trace_pc)
    );

    always #5 clk = ~clk;

    int unsigned n_checks = 0;
    int unsigned n_fail   = 0;

    // Per-cycle stimulus of one scenario; cycles past the end are idle.
    logic        st_v[$];
    logic [31:0] st_pc[$];
    logic [31:0] st_inst[$];
    logic [31:0] exp_pcs[$];

    task automatic check(input string tag, input logic [63:0] got, input logic [63:0] exp);
        n_checks++;
        if (got !== exp) begin
            n_fail++;
            $display("FAIL %s: got %0h, expected %0h", tag, got, exp);
        end
    endtask

    function automatic bit is_bad(input logic [31:0] w);
        if ($isunknown(w)) return 1'b1;
        return (w[1:0] != 2'b11) || (w == 32'h0) || (w == 32'hFFFF_FFFF);
    endfunction

    function automatic logic [31:0] rand_legal();
        logic [31:0] w;
        do w = $urandom | 32'h3; while (w == ECALL || w == 32'hFFFF_FFFF);
        return w;
    endfunction

    task automatic push(input logic v, input logic [31:0] pc, input logic [31:0] inst);
        st_v.push_back(v);
        st_pc.push_back(pc);
        st_inst.push_back(inst);
    endtask

    task automatic clear_stim();
        st_v.delete();
        st_pc.delete();
        st_inst.delete();
    endtask

    // Scenario-level model: first halt condition in the retire stream decides everything.
    task automatic model(output int det, output int cause, output logic [31:0] hpc);
        int          idle = 0;
        logic [31:0] last = '0;
        bit          done = 1'b0;
        exp_pcs.delete();
        det = 0;
        cause = 0;
        hpc = '0;
        for (int i = 0; !done && i < 100000; i++) begin
            if (i < st_v.size() && st_v[i]) begin
                exp_pcs.push_back(st_pc[i]);
                last = st_pc[i];
                idle = 0;
                if (st_inst[i] === ECALL) begin
                    det = i; cause = 1; hpc = st_pc[i]; done = 1'b1;
                end else if (is_bad(st_inst[i])) begin
                    det = i; cause = 2; hpc = st_pc[i]; done = 1'b1;
                end
            end else begin
                idle++;
                if (idle == TMO) begin
                    det = i; cause = 3; hpc = last; done = 1'b1;
                end
            end
        end
    endtask

    task automatic apply_reset(input string name);
        rst = 1'b0;
        ret_valid = 1'b0;
        trace_idx = '0;
        repeat (3) @(posedge clk);
        #1;
        check({name, "/rst_halted"}, halted, 0);
        check({name, "/rst_cause"}, halt_cause, 0);
        check({name, "/rst_pc"}, halt_pc, 0);
        check({name, "/rst_cycle"}, cycle_cnt, 0);
        check({name, "/rst_retire"}, retire_cnt, 0);
        check({name, "/rst_trace"}, trace_pc, 0);
        rst = 1'b1;
    endtask

    task automatic run_check(input string name, input bit do_reset);
        int          det;
        int          cause;
        logic [31:0] hpc;
        bit          hexp;
        if (do_reset) apply_reset(name);
        model(det, cause, hpc);
        for (int e = 0; e <= det + int'(DRAIN) + 3; e++) begin
            if (e < st_v.size()) begin
                ret_valid = st_v[e];
                ret_pc    = st_pc[e];
                ret_inst  = st_inst[e];
            end else begin
                ret_valid = 1'b0;
                ret_pc    = $urandom;
                ret_inst  = $urandom;
            end
            @(posedge clk);
            #1;
            hexp = (e >= det + int'(DRAIN) + 1);
            check({name, "/halted"}, halted, hexp);
            check({name, "/cause"}, halt_cause, hexp ? cause : 0);
            check({name, "/halt_pc"}, halt_pc, hexp ? hpc : 0);
        end
        ret_valid = 1'b0;
        check({name, "/cycle_cnt"}, cycle_cnt, det + 1);
        check({name, "/retire_cnt"}, retire_cnt, exp_pcs.size());
        for (int k = 0; k < DEPTH; k++) begin
            trace_idx = IW'(k);
            #1;
            check($sformatf("%s/trace%0d", name, k), trace_pc,
                  (k < exp_pcs.size()) ? exp_pcs[exp_pcs.size() - 1 - k] : 32'h0);
        end
        trace_idx = '0;
    endtask

    initial begin
        // ECALL after five NOPs; an illegal word and NOPs during drain must be ignored.
        clear_stim();
        for (int i = 0; i < 5; i++) push(1'b1, 32'(i * 4), NOP);
        push(1'b1, 32'd20, ECALL);
        push(1'b1, 32'h100, 32'h0);
        push(1'b1, 32'h104, NOP);
        run_check("ecall", 1'b1);

        clear_stim();
        push(1'b1, 32'h40, 32'h0);
        run_check("illegal_zero", 1'b1);

        clear_stim();
        push(1'b1, 32'h44, 32'h1234_5670);
        run_check("illegal_low00", 1'b1);

        clear_stim();
        push(1'b1, 32'h8, NOP);
        run_check("timeout", 1'b1);

        // Retire lands on the 16th idle cycle, so no timeout.
        clear_stim();
        push(1'b1, 32'h8, NOP);
        for (int i = 0; i < TMO - 1; i++) push(1'b0, 32'h0, 32'h0);
        push(1'b1, 32'hC, NOP);
        push(1'b1, 32'h10, ECALL);
        run_check("timeout_edge", 1'b1);

        clear_stim();
        for (int i = 0; i < 11; i++) push(1'b1, 32'(i * 4), NOP);
        push(1'b1, 32'h2C, ECALL);
        run_check("trace_wrap", 1'b1);

        // Reset mid-drain clears everything at once, then the monitor runs again.
        apply_reset("middrain");
        for (int i = 0; i < 4; i++) begin
            ret_valid = 1'b1;
            ret_pc    = 32'(i * 4);
            ret_inst  = (i == 3) ? ECALL : NOP;
            @(posedge clk);
            #1;
        end
        ret_valid = 1'b0;
        @(posedge clk);
        #2;
        check("middrain/retire_before", retire_cnt, 4);
        rst = 1'b0;
        #1;
        check("middrain/halted", halted, 0);
        check("middrain/cause", halt_cause, 0);
        check("middrain/pc", halt_pc, 0);
        check("middrain/cycle", cycle_cnt, 0);
        check("middrain/retire", retire_cnt, 0);
        check("middrain/trace", trace_pc, 0);
        @(posedge clk);
        #1;
        rst = 1'b1;
        clear_stim();
        push(1'b1, 32'h200, NOP);
        push(1'b1, 32'h204, 32'hFFFF_FFFF);
        run_check("after_reset", 1'b0);

`ifdef TRV_MON_XCHECK_EN
        clear_stim();
        push(1'b1, 32'h80, 32'hxxxx_xxxx);
        run_check("xcheck", 1'b1);
`endif

        for (int s = 0; s < 25; s++) begin
            int unsigned len;
            int unsigned r;
            clear_stim();
            len = $urandom_range(3, 30);
            for (int i = 0; i < len; i++) begin
                r = $urandom_range(0, 99);
                if (r < 4) begin
                    repeat ($urandom_range(10, 18)) push(1'b0, $urandom, $urandom);
                end else if (r < 25) begin
                    push(1'b0, $urandom, $urandom);
                end else if (r < 28) begin
                    push(1'b1, $urandom & ~32'h3, ECALL);
                end else if (r < 31) begin
                    push(1'b1, $urandom & ~32'h3, $urandom & ~32'h3);
                end else begin
                    push(1'b1, $urandom & ~32'h3, rand_legal());
                end
            end
            run_check($sformatf("rand%0d", s), 1'b1);
        end

        $display("End of test - %0d assertions evaluated, %0d failures", n_checks, n_fail);
        $finish;
    end

endmodule

// File: doc/trv_exec_monitor.md
Name: trv_exec_monitor

Overview:
- Synthesizable execution monitor for the TRV32I core; replaces ad-hoc bench logic for end-of-test detection.
- Observes the retired instruction stream and detects a halt condition: ECALL, illegal encoding, or a stall timeout.
- After a drain delay it latches a final status and keeps a circular trace of the last retired PCs for post-mortem readout.
- Sits beside the core in bench tops and FPGA debug builds.

Parameters:
- XLEN, 32, PC width.
- HALT_INST, 32'h00000073, instruction word treated as normal end of test.
- DRAIN_CYCLES, 4, cycles between detection and halted assertion (minimum 1).
- TIMEOUT, 1024, cycles without a retire before timeout; 0 disables timeout.
- TRACE_DEPTH, 8, PC trace entries (power of 2, 2..64).
- CNT_W, 32, width of the cycle and retire counters.

Ports:
- clk  in  1  clock.
- rst  in  1  asynchronous, active-low reset.
- ret_valid  in  1  one instruction retires this cycle.
- ret_pc  in  XLEN  PC of the retiring instruction.
- ret_inst  in  32  instruction word of the retiring instruction.
- halted  out  1  final status is valid; sticky until reset.
- halt_cause  out  2  0 none, 1 halt instruction, 2 illegal, 3 timeout.
- halt_pc  out  XLEN  PC that caused the halt; last retired PC for timeout.
- cycle_cnt  out  CNT_W  cycles spent in RUN.
- retire_cnt  out  CNT_W  retired instructions counted in RUN.
- trace_idx  in  log2(TRACE_DEPTH)  trace read index; 0 is the most recent entry.
- trace_pc  out  XLEN  combinational read of the selected entry.

Behaviour:
- Reset (rst low, asynchronous):
  - State goes to RUN.
  - All outputs, counters, the stall counter and all trace entries go to 0.
- FSM RUN -> DRAIN -> HALT.
  - HALT is left only by reset.
  - Reset asserted mid-DRAIN or in HALT aborts immediately.
- RUN:
  - cycle_cnt increments every cycle.
  - On ret_valid: retire_cnt increments, ret_pc is written to the trace (write pointer advances and wraps mod TRACE_DEPTH), and the stall counter clears.
  - Without ret_valid the stall counter increments.
- Detection, in priority order when ret_valid is high:
  - ret_inst == HALT_INST gives cause 1.
  - Otherwise an illegal word gives cause 2. Illegal means ret_inst[1:0] != 2'b11, or ret_inst == 0, or ret_inst == 32'hFFFFFFFF.
- Timeout: when TIMEOUT != 0, the stall counter reaching TIMEOUT with ret_valid low gives cause 3.
  - A retire in the same cycle as the timeout wins: no timeout, counter clears.
- On detection:
  - Cause and PC are latched into internal registers.
  - The detecting instruction is counted in retire_cnt and written to the trace.
  - FSM enters DRAIN with a drain counter of DRAIN_CYCLES-1.
- DRAIN:
  - Counters and trace are frozen.
  - Further ret_valid is ignored; no re-detection.
  - On the cycle the drain counter reaches 0, go to HALT.
- HALT:
  - halted, halt_cause and halt_pc are registered outputs and become visible in the cycle after entry to HALT.
  - Total latency from the detecting retire edge to halted high is DRAIN_CYCLES+1 edges.
  - halt_cause and halt_pc read 0 until halted rises.
- Counters saturate at all-ones; no wrap.
- Trace: entry k is the PC written k retires ago.
  - Entries not yet written read 0.
  - trace_idx >= number of retires returns 0.

Optional Feature:
- Macro TRV_MON_XCHECK_EN.
- Defined:
  - In simulation, any X/Z bit in ret_inst or ret_pc while ret_valid is high is detected as cause 2.
  - ret_valid itself being X/Z is also detected as cause 2, with halt_pc set to 0.
  - A $display of time and PC is emitted at detection.
- Not defined: no 4-state checks; X-valued inputs follow normal 2-state evaluation. This is the synthesis default.

Test Plan:
- Reset and halt instruction:
  - Stimulus: hold rst low 3 cycles, release, retire 5 NOPs (32'h00000013) at PCs 0,4,...,16, then 32'h00000073 at PC 20.
  - Required response: halted rises exactly DRAIN_CYCLES+1 edges after the ECALL edge; halt_cause=1; halt_pc=20; retire_cnt=6; trace_idx 0 reads 20, trace_idx 1 reads 16.
- Illegal word:
  - Stimulus: retire 32'h00000000 at PC 0x40.
  - Required response: cause 2, halt_pc=0x40.
  - Repeat with 32'h12345670 (low bits 00): cause 2.
- Timeout:
  - Stimulus: TIMEOUT=16; one retire at PC 8, then idle.
  - Required response: cause 3 detected on the 16th idle cycle; halt_pc=8.
  - A retire on exactly cycle 16 prevents the timeout.
- Trace wrap:
  - Stimulus: TRACE_DEPTH=8; retire 11 PCs 0x0..0x28, then ECALL.
  - Required response: trace_idx 0..7 read the ECALL PC and then 0x28 down to 0x10.
- Post-detection isolation:
  - Stimulus: during DRAIN, retire an illegal word.
  - Required response: cause stays 1 and retire_cnt is unchanged.
  - Stimulus: assert rst mid-DRAIN.
  - Required response: all outputs are 0 asynchronously, and the monitor resumes RUN after release.
- Xcheck (with TRV_MON_XCHECK_EN):
  - Stimulus: drive ret_inst=32'hxxxxxxxx with ret_valid=1 at PC 0x80.
  - Required response: cause 2, halt_pc=0x80.
